// File: rtl/key_note_arbiter_pkg.sv
// Shared note/octave encodings and key-vector helpers for the piano front end.
package piano_pkg;

  localparam int NUM_KEYS = 7;

  typedef logic [2:0] note_t;
  typedef logic [2:0] octave_t;

  localparam note_t   NOTE_SILENT = 3'd0;
  localparam note_t   NOTE_C      = 3'd1;
  localparam note_t   NOTE_D      = 3'd2;
  localparam note_t   NOTE_E      = 3'd3;
  localparam note_t   NOTE_F      = 3'd4;
  localparam note_t   NOTE_G      = 3'd5;
  localparam note_t   NOTE_A      = 3'd6;
  localparam note_t   NOTE_B      = 3'd7;
  localparam octave_t OCT_MAX     = 3'd7;

  // Note code of the highest set key, or silent when none are set.
  function automatic note_t hi_note(input logic [NUM_KEYS-1:0] v);
    note_t n;
    n = NOTE_SILENT;
    for (int k = 0; k < NUM_KEYS; k++)
      if (v[k]) n = note_t'(k + 1);
    return n;
  endfunction

  // Note code of the lowest set key, or silent when none are set.
  function automatic note_t lo_note(input logic [NUM_KEYS-1:0] v);
    note_t n;
    n = NOTE_SILENT;
    for (int k = NUM_KEYS - 1; k >= 0; k--)
      if (v[k]) n = note_t'(k + 1);
    return n;
  endfunction

  // One-hot key mask for a note code; silent maps to an empty mask.
  function automatic logic [NUM_KEYS-1:0] note_mask(input note_t n);
    logic [NUM_KEYS-1:0] m;
    m = '0;
    for (int k = 0; k < NUM_KEYS; k++)
      m[k] = (n == note_t'(k + 1));
    return m;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchroniser plus stable-count debouncer for one button.
// rise/fall are one-cycle strobes registered alongside the stable level.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt;

  // Raw input goes straight into the synchroniser, no logic in front.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], raw};
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b0;
      cnt    <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync_q[1] == stable) begin
        cnt <= '0;
      end else if (cnt == C_LAST) begin
        stable <= ~stable;
        cnt    <= '0;
        rise   <= ~stable;
        fall   <= stable;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/key_note_arbiter.sv
// Debounces 7 note keys and octave buttons, arbitrates last-pressed-wins
// with fallback to the lowest held key, and registers note/octave outputs.
module key_note_arbiter
  import piano_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int OCT_RESET       = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_raw,
  input  logic                oct_up_raw,
  input  logic                oct_dn_raw,
  output logic [2:0]          note,
  output logic [2:0]          octave,
  output logic                playing,
  output logic [NUM_KEYS-1:0] key_stable
);

  logic [NUM_KEYS-1:0] key_s, key_rise, key_fall;
  logic                up_s, up_rise, up_fall;
  logic                dn_s, dn_rise, dn_fall;
  logic                unused_btn;

  note_t   note_q, note_d;
  octave_t octave_q, octave_d;
  logic    playing_q;

  // One debouncer per key lane.
  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_db [NUM_KEYS-1:0] (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (key_raw),
    .stable (key_s),
    .rise   (key_rise),
    .fall   (key_fall)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_db (
    .clk(clk), .rst_n(rst_n), .raw(oct_up_raw),
    .stable(up_s), .rise(up_rise), .fall(up_fall)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn_db (
    .clk(clk), .rst_n(rst_n), .raw(oct_dn_raw),
    .stable(dn_s), .rise(dn_rise), .fall(dn_fall)
  );

  // Octave only reacts to press strobes; levels and releases are ignored.
  assign unused_btn = ^{up_s, up_fall, dn_s, dn_fall};

  // Next active note: presses win, active release falls back to lowest held.
  always_comb begin
    note_d = note_q;
    if (|key_rise)
      note_d = hi_note(key_rise);
    else if (|(key_fall & note_mask(note_q)))
      note_d = lo_note(key_s);
  end

  // Next octave: single press steps with saturation, simultaneous presses cancel.
  always_comb begin
    octave_d = octave_q;
    if (up_rise && !dn_rise && octave_q != OCT_MAX)
      octave_d = octave_q + 3'd1;
    else if (dn_rise && !up_rise && octave_q != 3'd0)
      octave_d = octave_q - 3'd1;
  end

  // Output registers; async reset silences the amplifier immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note_q    <= NOTE_SILENT;
      octave_q  <= octave_t'(OCT_RESET);
      playing_q <= 1'b0;
    end else begin
      note_q    <= note_d;
      octave_q  <= octave_d;
      playing_q <= (note_d != NOTE_SILENT);
    end
  end

  assign note       = note_q;
  assign octave     = octave_q;
  assign playing    = playing_q;
  assign key_stable = key_s;

endmodule

// File: tb/tb_key_note_arbiter.sv
// Directed bench for key_note_arbiter with a short debounce period.
module tb_key_note_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] key_raw;
  logic       oct_up_raw, oct_dn_raw;
  logic [2:0] note, octave;
  logic       playing;
  logic [6:0] key_stable;

  int checks   = 0;
  int failures = 0;

  key_note_arbiter #(.DEBOUNCE_CYCLES(4), .OCT_RESET(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_raw    (key_raw),
    .oct_up_raw (oct_up_raw),
    .oct_dn_raw (oct_dn_raw),
    .note       (note),
    .octave     (octave),
    .playing    (playing),
    .key_stable (key_stable)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Apply a key vector and let it debounce fully.
  task automatic keys(input logic [6:0] v);
    key_raw = v;
    tick(9);
  endtask

  // Press then release octave buttons, each through a full debounce.
  task automatic oct_btn(input logic up, input logic dn);
    oct_up_raw = up;
    oct_dn_raw = dn;
    tick(9);
    oct_up_raw = 1'b0;
    oct_dn_raw = 1'b0;
    tick(9);
  endtask

  logic [2:0] exp_oct;

  initial begin
    rst_n = 1'b0; key_raw = '0; oct_up_raw = 1'b0; oct_dn_raw = 1'b0;
    tick(3);
    chk("rst_note",   {5'd0, note},    8'd0);
    chk("rst_octave", {5'd0, octave},  8'd3);
    chk("rst_play",   {7'd0, playing}, 8'd0);
    chk("rst_stable", {1'b0, key_stable}, 8'd0);
    rst_n = 1'b1;
    tick(10);
    chk("idle_note",   {5'd0, note},   8'd0);
    chk("idle_octave", {5'd0, octave}, 8'd3);

    // Exact latency: 7 clocks from raw edge to note.
    key_raw = 7'b0000001;
    tick(6);
    chk("lat_note_6clk", {5'd0, note}, 8'd0);
    tick(1);
    chk("lat_note_7clk", {5'd0, note}, 8'd1);
    chk("lat_play",      {7'd0, playing}, 8'd1);
    chk("lat_stable",    {1'b0, key_stable}, 8'h01);
    keys(7'b0000000);
    chk("rel_note", {5'd0, note}, 8'd0);

    // Short bounce on key2 must be rejected.
    key_raw = 7'b0000100;
    tick(3);
    key_raw = 7'b0000000;
    tick(10);
    chk("bounce_stable", {1'b0, key_stable}, 8'h00);
    chk("bounce_note",   {5'd0, note},       8'd0);

    // Last-pressed wins, fallback to held key.
    keys(7'b0000001);
    chk("hold0_note", {5'd0, note}, 8'd1);
    keys(7'b0010001);
    chk("press4_note", {5'd0, note}, 8'd5);
    keys(7'b0000001);
    chk("rel4_note", {5'd0, note}, 8'd1);
    keys(7'b0000000);
    chk("rel0_note", {5'd0, note},    8'd0);
    chk("rel0_play", {7'd0, playing}, 8'd0);

    // Releasing a non-active key leaves the note alone.
    keys(7'b0000001);
    keys(7'b0010001);
    keys(7'b0010000);
    chk("rel_nonactive", {5'd0, note}, 8'd5);
    keys(7'b0000000);
    chk("rel_all", {5'd0, note}, 8'd0);

    // Simultaneous press: highest index wins; release falls to lowest held.
    keys(7'b0010100);
    chk("simul_note",   {5'd0, note}, 8'd5);
    chk("simul_stable", {1'b0, key_stable}, 8'h14);
    keys(7'b0000100);
    chk("simul_rel4", {5'd0, note}, 8'd3);
    keys(7'b0000000);

    // Octave up with saturation.
    exp_oct = 3'd3;
    for (int i = 0; i < 5; i++) begin
      oct_btn(1'b1, 1'b0);
      if (exp_oct != 3'd7) exp_oct = exp_oct + 3'd1;
      chk($sformatf("oct_up%0d", i), {5'd0, octave}, {5'd0, exp_oct});
    end
    oct_btn(1'b1, 1'b1);
    chk("oct_both", {5'd0, octave}, 8'd7);
    for (int i = 0; i < 8; i++) begin
      oct_btn(1'b0, 1'b1);
      if (exp_oct != 3'd0) exp_oct = exp_oct - 3'd1;
      chk($sformatf("oct_dn%0d", i), {5'd0, octave}, {5'd0, exp_oct});
    end
    chk("oct_note_untouched", {5'd0, note}, 8'd0);

    // Holding a key while the octave changes keeps the note.
    keys(7'b1000000);
    oct_up_raw = 1'b1;
    tick(9);
    chk("oct_hold_no_repeat", {5'd0, octave}, 8'd1);
    tick(20);
    chk("oct_hold_still",     {5'd0, octave}, 8'd1);
    chk("oct_keeps_note",     {5'd0, note},   8'd7);
    oct_up_raw = 1'b0;
    tick(9);

    // Async reset mid-note, key still held.
    keys(7'b0000001);
    chk("pre_rst_note", {5'd0, note}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_note",   {5'd0, note},    8'd0);
    chk("async_rst_octave", {5'd0, octave},  8'd3);
    chk("async_rst_play",   {7'd0, playing}, 8'd0);
    tick(2);
    rst_n = 1'b1;
    tick(6);
    chk("post_rst_6clk", {5'd0, note}, 8'd0);
    tick(1);
    chk("post_rst_7clk", {5'd0, note}, 8'd1);
    keys(7'b0000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
